// File: rtl/hs32_reg_sched.sv
// Register file slot scheduler for HS32: arbitrates one write or one dual-read per cycle
// between load/ALU writeback and decode, with a load scoreboard guarding RAW hazards.
module hs32_reg_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int MAX_WAIT   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_issue,
  input  logic [ADDR_WIDTH-1:0] ld_dst,
  output logic                  ld_ready,
  input  logic                  wb1_req,
  input  logic [ADDR_WIDTH-1:0] wb1_adr,
  input  logic [DATA_WIDTH-1:0] wb1_data,
  output logic                  wb1_gnt,
  input  logic                  wb0_req,
  input  logic [ADDR_WIDTH-1:0] wb0_adr,
  input  logic [DATA_WIDTH-1:0] wb0_data,
  output logic                  wb0_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_adr1,
  input  logic [ADDR_WIDTH-1:0] rd_adr2,
  output logic                  rd_gnt,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_wadr,
  output logic [DATA_WIDTH-1:0] rf_din,
  output logic [ADDR_WIDTH-1:0] rf_radr1,
  output logic [ADDR_WIDTH-1:0] rf_radr2,
  input  logic [DATA_WIDTH-1:0] rf_dout1,
  input  logic [DATA_WIDTH-1:0] rf_dout2
);

  localparam int NUM_REGS  = 1 << ADDR_WIDTH;
  localparam int CNT_WIDTH = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_WIDTH-1:0] WAIT_MAX = CNT_WIDTH'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} slot_t;

  slot_t                 state_reg, state_next;
  logic [NUM_REGS-1:0]   pending_reg, pending_next;
  logic [NUM_REGS-1:0]   set_mask, clr_mask;
  logic [CNT_WIDTH-1:0]  wait_cnt_reg, wait_cnt_next;

  logic                  rf_we_reg, rd_valid_reg;
  logic [ADDR_WIDTH-1:0] rf_wadr_reg, rf_wadr_next;
  logic [DATA_WIDTH-1:0] rf_din_reg, rf_din_next;
  logic [ADDR_WIDTH-1:0] rf_radr1_reg, rf_radr1_next;
  logic [ADDR_WIDTH-1:0] rf_radr2_reg, rf_radr2_next;

  logic ld_acc, wb1_acc;
  logic pend_hit, wb0_hit, wb1_hit, rd_elig, boost, wr_gnt;

  assign ld_ready = !reset && !pending_reg[ld_dst];
  assign ld_acc   = ld_issue && ld_ready;
  assign wb1_acc  = wb1_req && wb1_gnt;

  // Per-register scoreboard update; a same-cycle set overrides the clear.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
      assign set_mask[gi]     = ld_acc  && (ld_dst  == ADDR_WIDTH'(gi));
      assign clr_mask[gi]     = wb1_acc && (wb1_adr == ADDR_WIDTH'(gi));
      assign pending_next[gi] = set_mask[gi] | (pending_reg[gi] & ~clr_mask[gi]);
    end
  endgenerate

  // A read touching a register with an outstanding load or a concurrent writer must wait.
  assign pend_hit = pending_reg[rd_adr1] | pending_reg[rd_adr2];
  assign wb0_hit  = wb0_req && ((wb0_adr == rd_adr1) || (wb0_adr == rd_adr2));
  assign wb1_hit  = wb1_req && ((wb1_adr == rd_adr1) || (wb1_adr == rd_adr2));
  assign rd_elig  = rd_req && !pend_hit && !wb0_hit && !wb1_hit;
  assign boost    = rd_elig && (wait_cnt_reg == WAIT_MAX);
  assign wr_gnt   = wb0_gnt || wb1_gnt;

  always_comb begin
    wb1_gnt    = 1'b0;
    wb0_gnt    = 1'b0;
    rd_gnt     = 1'b0;
    state_next = S_IDLE;
    if (!reset) begin
      if (boost)        rd_gnt  = 1'b1;
      else if (wb1_req) wb1_gnt = 1'b1;
      else if (wb0_req) wb0_gnt = 1'b1;
      else if (rd_elig) rd_gnt  = 1'b1;
    end
    if (wb1_gnt || wb0_gnt) state_next = S_WR;
    else if (rd_gnt)        state_next = S_RD;
  end

  always_comb begin
    rf_wadr_next  = rf_wadr_reg;
    rf_din_next   = rf_din_reg;
    rf_radr1_next = rf_radr1_reg;
    rf_radr2_next = rf_radr2_reg;
    if (wb1_gnt) begin
      rf_wadr_next = wb1_adr;
      rf_din_next  = wb1_data;
    end else if (wb0_gnt) begin
      rf_wadr_next = wb0_adr;
      rf_din_next  = wb0_data;
    end
    if (rd_gnt) begin
      rf_radr1_next = rd_adr1;
      rf_radr2_next = rd_adr2;
    end
  end

  // Counts writer wins against an eligible reader; stalls due to hazards do not count.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!rd_req || rd_gnt) begin
      wait_cnt_next = '0;
    end else if (rd_elig && wr_gnt && (wait_cnt_reg != WAIT_MAX)) begin
      wait_cnt_next = wait_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      pending_reg  <= '0;
      wait_cnt_reg <= '0;
      rf_we_reg    <= 1'b0;
      rf_wadr_reg  <= '0;
      rf_din_reg   <= '0;
      rf_radr1_reg <= '0;
      rf_radr2_reg <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      wait_cnt_reg <= wait_cnt_next;
      rf_we_reg    <= (state_next == S_WR);
      rf_wadr_reg  <= rf_wadr_next;
      rf_din_reg   <= rf_din_next;
      rf_radr1_reg <= rf_radr1_next;
      rf_radr2_reg <= rf_radr2_next;
      rd_valid_reg <= (state_reg == S_RD);
    end
  end

  assign rf_we    = rf_we_reg;
  assign rf_wadr  = rf_wadr_reg;
  assign rf_din   = rf_din_reg;
  assign rf_radr1 = rf_radr1_reg;
  assign rf_radr2 = rf_radr2_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data1 = rf_dout1;
  assign rd_data2 = rf_dout2;

endmodule
